// File: rtl/boot_pkg.sv
// boot_pkg: shared types and constants for the serial boot loader.
//   - loader_state_t : loader FSM states
//   - rx_state_t     : UART receiver FSM states
//   - HDR_BYTES, BYTES_PER_WORD : image framing constants
//   - is_oversize()  : header word-count range check
package boot_pkg;

  typedef enum logic [2:0] {
    HDR_LO = 3'd0,
    HDR_HI = 3'd1,
    DATA   = 3'd2,
    DONE   = 3'd3,
    ERROR  = 3'd4
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  // True when a header word count exceeds the largest image we can hold.
  function automatic logic is_oversize(input logic [15:0] n, input int unsigned max_words);
    return (32'(n) > 32'(max_words));
  endfunction

endpackage

// File: rtl/boot_loader_uart_rx.sv
// uart_rx: 8N1 UART receiver with a 2-flop input synchronizer.
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   rx         in   serial line, idles high, asynchronous to clk
//   byte_out   out  last received byte (valid with byte_valid)
//   byte_valid out  one-cycle pulse, good stop bit
//   frame_err  out  one-cycle pulse, stop bit sampled low
module uart_rx
  import boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t        state_r, state_next_s;
  logic             rx_meta_r, rx_sync_r;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]       bit_idx_r, bit_idx_s;
  logic [7:0]       shift_r, shift_s;
  logic             byte_valid_r, byte_valid_s;
  logic             frame_err_r, frame_err_s;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= RX_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Receiver next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      RX_IDLE: begin
        if (!rx_sync_r) state_next_s = RX_START;
        else            state_next_s = RX_IDLE;
      end
      RX_START: begin
        // Mid-start re-check: a high line here was only a glitch.
        if (cnt_r == HALF_M1) state_next_s = rx_sync_r ? RX_IDLE : RX_DATA;
        else                  state_next_s = RX_START;
      end
      RX_DATA: begin
        if (cnt_r == FULL_M1 && bit_idx_r == 3'd7) state_next_s = RX_STOP;
        else                                       state_next_s = RX_DATA;
      end
      RX_STOP: begin
        if (cnt_r == FULL_M1) state_next_s = RX_IDLE;
        else                  state_next_s = RX_STOP;
      end
      default: state_next_s = RX_IDLE;
    endcase
  end

  // Receiver datapath next values: baud counter, bit index, shifter, pulses.
  always_comb begin
    cnt_s        = cnt_r;
    bit_idx_s    = bit_idx_r;
    shift_s      = shift_r;
    byte_valid_s = 1'b0;
    frame_err_s  = 1'b0;
    case (state_r)
      RX_IDLE: begin
        cnt_s     = '0;
        bit_idx_s = 3'd0;
      end
      RX_START: begin
        if (cnt_r == HALF_M1) cnt_s = '0;
        else                  cnt_s = cnt_r + CNT_W'(1);
      end
      RX_DATA: begin
        if (cnt_r == FULL_M1) begin
          cnt_s     = '0;
          shift_s   = {rx_sync_r, shift_r[7:1]};
          bit_idx_s = bit_idx_r + 3'd1;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_r == FULL_M1) begin
          cnt_s        = '0;
          byte_valid_s = rx_sync_r;
          frame_err_s  = ~rx_sync_r;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        cnt_s     = '0;
        bit_idx_s = 3'd0;
      end
    endcase
  end

  // Receiver datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r        <= '0;
      bit_idx_r    <= 3'd0;
      shift_r      <= 8'd0;
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      cnt_r        <= cnt_s;
      bit_idx_r    <= bit_idx_s;
      shift_r      <= shift_s;
      byte_valid_r <= byte_valid_s;
      frame_err_r  <= frame_err_s;
    end
  end

  assign byte_out   = shift_r;
  assign byte_valid = byte_valid_r;
  assign frame_err  = frame_err_r;

endmodule

// File: rtl/boot_loader.sv
// boot_loader: loads a program image received over UART into instruction
// memory and holds the core in reset until the image is complete.
// Image: 2-byte little-endian word count N, then N little-endian 32-bit words.
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous active-low reset
//   rx          in   UART line (8N1)
//   imem_we     out  one-cycle instruction-memory write strobe
//   imem_addr   out  word address of the write (held between strobes)
//   imem_wdata  out  instruction word of the write (held between strobes)
//   core_hold   out  high keeps the core in reset
//   done        out  sticky, image loaded
//   error       out  sticky, load aborted
module boot_loader
  import boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int ADDR_WIDTH   = 8,
  parameter int MAX_WORDS    = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_hold,
  output logic                  done,
  output logic                  error
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [7:0] rx_byte_s;
  logic       rx_valid_s;
  logic       rx_ferr_s;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .byte_out  (rx_byte_s),
    .byte_valid(rx_valid_s),
    .frame_err (rx_ferr_s)
  );

  loader_state_t         state_r, state_next_s;
  logic [15:0]           count_r, count_s;
  logic [1:0]            byte_idx_r, byte_idx_s;
  logic [ADDR_WIDTH:0]   word_idx_r, word_idx_s;
  logic [31:0]           word_r, word_s;
  logic [15:0]           hdr_count_s;
  logic [16:0]           word_inc_s;
  logic                  last_word_s;

  logic                  imem_we_r, imem_we_s;
  logic [ADDR_WIDTH-1:0] imem_addr_r, imem_addr_s;
  logic [31:0]           imem_wdata_r, imem_wdata_s;
  logic                  done_r, done_s;
  logic                  error_r, error_s;
  logic                  core_hold_r, core_hold_s;

  assign hdr_count_s = {rx_byte_s, count_r[7:0]};
  assign word_inc_s  = 17'(word_idx_r) + 17'd1;
  assign last_word_s = (word_inc_s == {1'b0, count_r});

  // Loader state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= HDR_LO;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Loader next-state logic; a framing error aborts any active load.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      HDR_LO: begin
        if (rx_ferr_s)       state_next_s = ERROR;
        else if (rx_valid_s) state_next_s = HDR_HI;
        else                 state_next_s = HDR_LO;
      end
      HDR_HI: begin
        if (rx_ferr_s) begin
          state_next_s = ERROR;
        end else if (rx_valid_s) begin
          if (hdr_count_s == 16'd0)                         state_next_s = DONE;
          else if (is_oversize(hdr_count_s, MAX_WORDS))     state_next_s = ERROR;
          else                                              state_next_s = DATA;
        end else begin
          state_next_s = HDR_HI;
        end
      end
      DATA: begin
        if (rx_ferr_s)                                                state_next_s = ERROR;
        else if (rx_valid_s && byte_idx_r == LAST_BYTE && last_word_s) state_next_s = DONE;
        else                                                          state_next_s = DATA;
      end
      DONE:    state_next_s = DONE;
      ERROR:   state_next_s = ERROR;
      default: state_next_s = ERROR;
    endcase
  end

  // Loader datapath and output next values.
  always_comb begin
    count_s      = count_r;
    byte_idx_s   = byte_idx_r;
    word_idx_s   = word_idx_r;
    word_s       = word_r;
    imem_we_s    = 1'b0;
    imem_addr_s  = imem_addr_r;
    imem_wdata_s = imem_wdata_r;
    case (state_r)
      HDR_LO: begin
        if (rx_valid_s) count_s[7:0] = rx_byte_s;
        else            count_s      = count_r;
      end
      HDR_HI: begin
        if (rx_valid_s) begin
          count_s[15:8] = rx_byte_s;
          byte_idx_s    = 2'd0;
          word_idx_s    = '0;
        end else begin
          count_s = count_r;
        end
      end
      DATA: begin
        if (rx_valid_s && !rx_ferr_s) begin
          case (byte_idx_r)
            2'd0:    word_s[7:0]   = rx_byte_s;
            2'd1:    word_s[15:8]  = rx_byte_s;
            2'd2:    word_s[23:16] = rx_byte_s;
            2'd3:    word_s[31:24] = rx_byte_s;
            default: word_s        = word_r;
          endcase
          byte_idx_s = byte_idx_r + 2'd1;
          if (byte_idx_r == LAST_BYTE) begin
            imem_we_s    = 1'b1;
            imem_addr_s  = word_idx_r[ADDR_WIDTH-1:0];
            imem_wdata_s = {rx_byte_s, word_r[23:0]};
            word_idx_s   = word_idx_r + (ADDR_WIDTH+1)'(1);
          end else begin
            imem_we_s = 1'b0;
          end
        end else begin
          word_s = word_r;
        end
      end
      DONE:    word_s = word_r;
      ERROR:   word_s = word_r;
      default: word_s = word_r;
    endcase
  end

  // Status next values. done waits one cycle behind the final write strobe
  // so the last word lands before the core leaves reset; an empty image has
  // no strobe and finishes straight away.
  always_comb begin
    done_s      = done_r | ((state_next_s == DONE) & ~imem_we_s);
    error_s     = error_r | (state_next_s == ERROR);
    core_hold_s = ~done_s;
  end

  // Loader datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r      <= 16'd0;
      byte_idx_r   <= 2'd0;
      word_idx_r   <= '0;
      word_r       <= 32'd0;
      imem_we_r    <= 1'b0;
      imem_addr_r  <= '0;
      imem_wdata_r <= 32'd0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      core_hold_r  <= 1'b1;
    end else begin
      count_r      <= count_s;
      byte_idx_r   <= byte_idx_s;
      word_idx_r   <= word_idx_s;
      word_r       <= word_s;
      imem_we_r    <= imem_we_s;
      imem_addr_r  <= imem_addr_s;
      imem_wdata_r <= imem_wdata_s;
      done_r       <= done_s;
      error_r      <= error_s;
      core_hold_r  <= core_hold_s;
    end
  end

  assign imem_we    = imem_we_r;
  assign imem_addr  = imem_addr_r;
  assign imem_wdata = imem_wdata_r;
  assign done       = done_r;
  assign error      = error_r;
  assign core_hold  = core_hold_r;

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed bench for boot_loader with CLKS_PER_BIT=4.
module tb_boot_loader;

  localparam int CPB = 4;
  localparam int AW  = 8;

  logic          clk;
  logic          reset;
  logic          rx;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_hold;
  logic          done;
  logic          error;

  int checks = 0;
  int errors = 0;

  // Activity log filled by the monitor.
  int            cyc = 0;
  int            nwr = 0;
  int            nbv = 0;
  int            bv_cyc = -1;
  int            done_cyc = -1;
  int            hold_cyc = -1;
  logic [AW-1:0] wa [16];
  logic [31:0]   wd [16];
  int            wc [16];

  boot_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_WIDTH  (AW),
    .MAX_WORDS   (256)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .core_hold (core_hold),
    .done      (done),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record writes, received bytes and status edges, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      nwr = 0; nbv = 0; bv_cyc = -1; done_cyc = -1; hold_cyc = -1;
    end else begin
      if (imem_we) begin
        if (nwr < 16) begin
          wa[nwr] = imem_addr; wd[nwr] = imem_wdata; wc[nwr] = cyc;
        end
        nwr++;
      end
      if (dut.u_rx.byte_valid) begin
        nbv++; bv_cyc = cyc;
      end
      if (done && done_cyc < 0) done_cyc = cyc;
      if (!core_hold && hold_cyc < 0) hold_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_two_word();
    send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h93, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h50, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'h10, 1'b1); send_byte(8'h00, 1'b1);
    repeat (6) @(negedge clk);
  endtask

  task automatic check_two_word(input string tag);
    check({tag, "_nwr"},   32'(nwr), 32'd2);
    check({tag, "_a0"},    32'(wa[0]), 32'd0);
    check({tag, "_d0"},    wd[0], 32'h0050_0093);
    check({tag, "_a1"},    32'(wa[1]), 32'd1);
    check({tag, "_d1"},    wd[1], 32'h0010_0113);
    check({tag, "_done"},  32'(done), 32'd1);
    check({tag, "_hold"},  32'(core_hold), 32'd0);
    check({tag, "_err"},   32'(error), 32'd0);
    check({tag, "_dcyc"},  32'(done_cyc), 32'(wc[1] + 1));
    check({tag, "_hcyc"},  32'(hold_cyc), 32'(wc[1] + 1));
  endtask

  initial begin
    reset = 1'b0;
    rx    = 1'b1;
    @(negedge clk);
    #1;
    // Reset values
    check("rst_we",    32'(imem_we), 32'd0);
    check("rst_addr",  32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_hold",  32'(core_hold), 32'd1);
    check("rst_done",  32'(done), 32'd0);
    check("rst_err",   32'(error), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Two-word load
    send_two_word();
    check_two_word("two");
    check("two_hold_addr",  32'(imem_addr), 32'd1);
    check("two_hold_wdata", imem_wdata, 32'h0010_0113);

    // Empty image, then bytes after DONE are ignored
    do_reset();
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    repeat (4) @(negedge clk);
    check("empty_nwr",  32'(nwr), 32'd0);
    check("empty_done", 32'(done), 32'd1);
    check("empty_hold", 32'(core_hold), 32'd0);
    check("empty_dcyc", 32'(done_cyc), 32'(bv_cyc + 1));
    send_byte(8'h55, 1'b0);
    send_byte(8'hAA, 1'b1);
    check("done_ign_nwr", 32'(nwr), 32'd0);
    check("done_ign_err", 32'(error), 32'd0);

    // Oversize header N=257; later valid image ignored
    do_reset();
    send_byte(8'h01, 1'b1); send_byte(8'h01, 1'b1);
    repeat (4) @(negedge clk);
    check("over_err",  32'(error), 32'd1);
    check("over_hold", 32'(core_hold), 32'd1);
    send_two_word();
    check("over_nwr",  32'(nwr), 32'd0);
    check("over_done", 32'(done), 32'd0);
    check("over_err2", 32'(error), 32'd1);
    check("over_hold2", 32'(core_hold), 32'd1);

    // N=256 is the largest accepted size
    do_reset();
    send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    repeat (4) @(negedge clk);
    check("max_err",  32'(error), 32'd0);
    check("max_done", 32'(done), 32'd0);

    // Framing error on a data byte
    do_reset();
    send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h93, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h50, 1'b1); send_byte(8'h00, 1'b1);
    check("ferr_err",  32'(error), 32'd1);
    check("ferr_nwr",  32'(nwr), 32'd0);
    check("ferr_done", 32'(done), 32'd0);
    check("ferr_hold", 32'(core_hold), 32'd1);

    // Short glitch in idle, then a normal load
    do_reset();
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_nbv", 32'(nbv), 32'd0);
    send_two_word();
    check_two_word("glitch");

    // Reset mid-word, then reload
    do_reset();
    send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h93, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h50, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1); send_byte(8'h01, 1'b1);
    check("mid_pre_wdata", imem_wdata, 32'h0050_0093);
    reset = 1'b0;
    #1;
    check("mid_we",    32'(imem_we), 32'd0);
    check("mid_addr",  32'(imem_addr), 32'd0);
    check("mid_wdata", imem_wdata, 32'd0);
    check("mid_hold",  32'(core_hold), 32'd1);
    check("mid_done",  32'(done), 32'd0);
    check("mid_err",   32'(error), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
    repeat (4) @(negedge clk);
    check("reload_nwr",  32'(nwr), 32'd1);
    check("reload_a0",   32'(wa[0]), 32'd0);
    check("reload_d0",   wd[0], 32'h1234_5678);
    check("reload_done", 32'(done), 32'd1);
    check("reload_dcyc", 32'(done_cyc), 32'(wc[0] + 1));
    check("reload_err",  32'(error), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
# boot_loader

Serial program loader that sits upstream of the single-cycle RISC-V core's instruction memory. It receives a program image over an 8N1 UART line, assembles little-endian 32-bit words, and writes them into consecutive word addresses of instruction memory. While loading, it holds the core in reset and releases it only after the full image has arrived. The PC advances by 1 per instruction, so the write address is a word index starting at 0.

## Interface
Parameters:
- CLKS_PER_BIT, 16: clk cycles per UART bit, ≥ 4.
- ADDR_WIDTH, 8: width of the instruction-memory word address.
- MAX_WORDS, 256: largest accepted image, ≤ 2^ADDR_WIDTH.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low; one clock; reset is asynchronous and active-low.
- rx  in  1  UART receive line; idles high; asynchronous to clk.
- imem_we  out  1  one-cycle write strobe to instruction memory.
- imem_addr  out  ADDR_WIDTH  word address for the write.
- imem_wdata  out  32  instruction word for the write.
- core_hold  out  1  high = keep core (PC) in reset; top level ties it to the core reset.
- done  out  1  sticky; image loaded successfully.
- error  out  1  sticky; load aborted.

## Operation
- Image format: 2-byte header, word count N, little-endian (low byte first). Then N words, 4 bytes each, little-endian.
- Loader FSM states:
  - HDR_LO: capture count[7:0], go to HDR_HI.
  - HDR_HI: capture count[15:8]. If N==0, go to DONE. If N>MAX_WORDS, go to ERROR. Otherwise go to DATA with the byte index and word index cleared.
  - DATA: shift each byte into word bits [8k+7:8k] for k = 0..3.
    - On the 4th byte, pulse imem_we with imem_addr = word index and imem_wdata = assembled word.
    - Then increment the word index; when it reaches N, go to DONE.
  - DONE: done=1, core_hold=0. All further rx bytes are ignored.
  - ERROR: error=1, core_hold=1. Terminal until reset.
- A framing error (stop bit sampled low) in any state other than DONE or ERROR sends the FSM to ERROR. No partial word is written.
- UART receiver:
  - rx passes through a 2-flop synchronizer first.
  - A falling edge starts a bit counter. At CLKS_PER_BIT/2 the start bit is re-sampled; if it is high, this is a false start and the receiver returns to idle.
  - Data bits are sampled LSB first, every CLKS_PER_BIT cycles after the start-bit midpoint.
  - The stop bit is sampled at its midpoint. Then the receiver pulses byte_valid or frame_err for one cycle and returns to idle, immediately ready for the next start edge.
- imem_addr and imem_wdata hold their last written values between strobes.

## Timing
- Reset values: imem_we=0, imem_addr=0, imem_wdata=0, core_hold=1, done=0, error=0. Loader FSM=HDR_LO; receiver idle.
- Reset asserted mid-operation: reset values are forced asynchronously. Memory contents already written are left as-is; the next image overwrites from address 0.
- Sample latency: synchronizer adds 2 cycles. A data bit's sample is taken (2 + CLKS_PER_BIT/2 + b·CLKS_PER_BIT) cycles after the rx edge that begins the start bit, for bit b = 1..8 and stop = 9.
- byte_valid occurs on the cycle after the stop-bit sample.
- imem_we is registered: high exactly one cycle, the cycle after byte_valid of the 4th byte of a word.
- For the last word: done rises and core_hold falls on the cycle after that imem_we. The write has therefore completed before the core leaves reset.
- For N==0: done rises the cycle after HDR_HI's byte_valid.
- Counts: word index is ADDR_WIDTH+1 bits, so N==MAX_WORDS==2^ADDR_WIDTH is representable. Byte index is 2 bits and wraps 3→0.

## Structure
- Shared package boot_pkg:
  - loader state enum {HDR_LO, HDR_HI, DATA, DONE, ERROR};
  - receiver state enum {RX_IDLE, RX_START, RX_DATA, RX_STOP};
  - constant HDR_BYTES=2, BYTES_PER_WORD=4.
- One sub-module, uart_rx:
  - Parameter CLKS_PER_BIT.
  - Ports clk, reset, rx, byte_out[7:0], byte_valid, frame_err.
  - Contains the synchronizer and baud counter.
- boot_loader contains the loader FSM, word assembly, counters and output registers.

## Test plan
All scenarios use CLKS_PER_BIT=4, ADDR_WIDTH=8, MAX_WORDS=256.
- Two-word load: bytes 02 00, 93 00 50 00, 13 01 10 00 -> imem_we pulses at addr 0 with 0x00500093 and at addr 1 with 0x00100113. done=1 and core_hold=0 on the cycle after the 2nd pulse; error=0.
- Empty image: bytes 00 00 -> no imem_we; done=1 one cycle after the 2nd byte_valid.
- Oversize: header 01 01 (N=257) -> error=1, core_hold stays 1, no imem_we. A following valid image is ignored until reset.
- Framing error: header 01 00, then a data byte with stop bit low -> error=1, no imem_we.
- Glitch: rx low for 1 cycle (less than CLKS_PER_BIT/2) in idle -> no byte_valid; a subsequent valid two-word load succeeds.
- Reset mid-word: drop reset after 2 of 4 data bytes -> all outputs at reset values immediately. A full reload of 01 00 78 56 34 12 writes 0x12345678 at addr 0, then done=1.
